cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Transmitter side of the common data bus (CDB); the ROB's writeback port is the receiver.
- Collects completed results from NUM_FU functional units through valid/ready handshakes, buffering each unit's results in a 2-entry FIFO.
- Each cycle, grants one buffered result round-robin and broadcasts it from a registered CDB output to the ROB, reservation stations and physical regfile.
- Flush clears all in-flight results.

Parameters:
- NUM_FU, 4, number of functional-unit result ports (2..8).
- ROB_IDX_W, 4, ROB index width.
- P_REG_DEPTH, 6, physical register index width.
- R_REG_DEPTH, 5, architectural register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  pipeline flush; clears all state
- fu_valid  in  NUM_FU  per-FU result valid
- fu_ready  out  NUM_FU  per-FU buffer can accept
- fu_rob_index  in  NUM_FU*ROB_IDX_W  packed; FU i at [i*ROB_IDX_W +: ROB_IDX_W]
- fu_pd  in  NUM_FU*P_REG_DEPTH  packed destination physical reg
- fu_rd  in  NUM_FU*R_REG_DEPTH  packed destination arch reg
- fu_result  in  NUM_FU*32  packed result
- fu_regf_we  in  NUM_FU  result writes regfile/RAT
- fu_jump  in  NUM_FU  control-transfer taken
- fu_br_flush  in  NUM_FU  mispredict, flush required at commit
- cdb_valid  out  1  broadcast valid
- cdb_rob_index  out  ROB_IDX_W
- cdb_pd  out  P_REG_DEPTH
- cdb_rd  out  R_REG_DEPTH
- cdb_result  out  32
- cdb_regf_we  out  1
- cdb_jump  out  1
- cdb_br_flush  out  1

Behaviour:
- Reset: all FIFOs empty (count=0, pointers 0); rr_ptr=0; cdb_valid=0 and all cdb_* fields 0; fu_ready all 1 in the cycle after reset.
- Per-FU FIFO:
  - 2 entries, 1-bit rd/wr pointers, 2-bit count.
  - fu_ready[i] = (count_i != 2). It depends only on registered count, not on same-cycle grant.
  - Push when fu_valid[i] && fu_ready[i].
  - Pop when FU i is granted.
  - Push+pop in the same cycle: count unchanged, order preserved.
- Arbitration (combinational, over non-empty FIFOs):
  - Search starts at rr_ptr and proceeds upward modulo NUM_FU; the first non-empty FIFO wins.
  - No request: no grant, rr_ptr holds.
  - Grant to i: rr_ptr <= (i+1) mod NUM_FU, with wrap from NUM_FU-1 to 0.
- Output register:
  - Every edge, cdb_valid <= any_grant.
  - On grant, fields load from the winner's FIFO head; otherwise all fields load 0.
  - Fields are 0 whenever cdb_valid=0.
  - Exactly one broadcast per cycle max.
- Latency: a handshake sampled at edge k yields cdb_valid=1 in the cycle after edge k+1 when uncontended. One-cycle minimum FIFO residency; no bypass.
- Throughput: 1 result/cycle total. A single FU streaming continuously sustains 1/cycle when it is the only requester.
- Flush:
  - At a flush edge, all FIFOs empty, rr_ptr=0 and cdb_valid=0 with fields cleared.
  - Handshakes in the flush cycle are discarded.
  - The grant in the flush cycle is discarded.
  - Flush has priority over push, pop and rst-free operation. rst has priority over flush.
- Reset mid-operation: identical to flush. Buffered results are lost.
- fu_valid while fu_ready=0: ignored. The FU must hold its data.
- ROB index/pd are passed through unchecked; tag matching is the receiver's job.

Optional Feature:
- Macro: CDB_FLUSH_PRIO_EN.
- Defined: any non-empty FIFO whose head has br_flush=1 wins over non-flush heads.
  - Among several flush heads, the lowest FU index wins.
  - rr_ptr still updates to winner+1.
  - Non-flush arbitration is unchanged.
- Undefined: pure round-robin; br_flush is only passed through.

Test Plan:
- Single FU: after reset, FU2 pulses fu_valid with rob_index=5, pd=12, rd=3, result=0xDEADBEEF, regf_we=1 -> two edges later cdb_valid=1 with identical fields for exactly one cycle; cdb fields 0 the next cycle.
- Contention: all 4 FUs push in one cycle, rr_ptr=0 -> broadcasts in FU order 0,1,2,3 on consecutive cycles; rr_ptr ends 0 after wrap.
- Backpressure: FU1 pushes 3 consecutive cycles while FU0 is also kept busy so FU1 is not granted -> fu_ready[1]=0 after 2 pushes, third push dropped; FU1 results emerge in push order without loss.
- Flush mid-operation: 3 FIFOs each hold 2 entries, assert flush for one cycle -> next cycle cdb_valid=0, all fu_ready=1; no stale broadcast ever appears.
- Push/pop overlap: FU0 alone streams a result every cycle for 8 cycles -> 8 consecutive cdb_valid cycles, fu_ready[0] never drops.
- CDB_FLUSH_PRIO_EN: rr_ptr=0; FU0 head br_flush=0, FU3 head br_flush=1 -> defined: FU3 broadcast first; undefined: FU0 first.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB transmitter: per-FU 2-entry result FIFOs, round-robin grant, registered broadcast; optional CDB_FLUSH_PRIO_EN
module cdb_arbiter #(
    parameter int NUM_FU      = 4,
    parameter int ROB_IDX_W   = 4,
    parameter int P_REG_DEPTH = 6,
    parameter int R_REG_DEPTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [NUM_FU-1:0]               fu_valid,
    output logic [NUM_FU-1:0]               fu_ready,
    input  logic [NUM_FU*ROB_IDX_W-1:0]     fu_rob_index,
    input  logic [NUM_FU*P_REG_DEPTH-1:0]   fu_pd,
    input  logic [NUM_FU*R_REG_DEPTH-1:0]   fu_rd,
    input  logic [NUM_FU*32-1:0]            fu_result,
    input  logic [NUM_FU-1:0]               fu_regf_we,
    input  logic [NUM_FU-1:0]               fu_jump,
    input  logic [NUM_FU-1:0]               fu_br_flush,
    output logic                            cdb_valid,
    output logic [ROB_IDX_W-1:0]            cdb_rob_index,
    output logic [P_REG_DEPTH-1:0]          cdb_pd,
    output logic [R_REG_DEPTH-1:0]          cdb_rd,
    output logic [31:0]                     cdb_result,
    output logic                            cdb_regf_we,
    output logic                            cdb_jump,
    output logic                            cdb_br_flush
);

    // Entry layout (MSB..LSB): rob_index, pd, rd, result, regf_we, jump, br_flush
    localparam int EW      = ROB_IDX_W + P_REG_DEPTH + R_REG_DEPTH + 35;
    localparam int PTR_W   = $clog2(NUM_FU);
    localparam int RES_LSB = 3;
    localparam int RD_LSB  = 35;
    localparam int PD_LSB  = RD_LSB + R_REG_DEPTH;
    localparam int ROB_LSB = PD_LSB + P_REG_DEPTH;

    logic [NUM_FU-1:0] nonempty;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [EW-1:0]     head [NUM_FU];

    logic              gnt_valid;
    logic [PTR_W-1:0]  gnt_idx;
    logic [EW-1:0]     gnt_entry;
    logic [PTR_W-1:0]  rr_q;
    logic [PTR_W-1:0]  rr_d;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        logic [EW-1:0] mem_q [2];
        logic [1:0]    cnt_q;
        logic          wr_q;
        logic          rd_q;
        logic [EW-1:0] din;

        assign din = {fu_rob_index[i*ROB_IDX_W +: ROB_IDX_W],
                      fu_pd[i*P_REG_DEPTH +: P_REG_DEPTH],
                      fu_rd[i*R_REG_DEPTH +: R_REG_DEPTH],
                      fu_result[i*32 +: 32],
                      fu_regf_we[i], fu_jump[i], fu_br_flush[i]};

        // Ready comes from the registered count only, so a full FIFO stays
        // closed even in the cycle it is being drained.
        assign fu_ready[i] = (cnt_q != 2'd2);
        assign nonempty[i] = (cnt_q != 2'd0);
        assign head[i]     = mem_q[rd_q];
        assign push[i]     = fu_valid[i] & fu_ready[i];
        assign pop[i]      = gnt_valid & (gnt_idx == PTR_W'(i));

        // Pointer and occupancy tracking; flush and reset drop everything
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                cnt_q <= 2'd0;
                wr_q  <= 1'b0;
                rd_q  <= 1'b0;
            end else begin
                if (push[i]) wr_q <= ~wr_q;
                if (pop[i])  rd_q <= ~rd_q;
                case ({push[i], pop[i]})
                    2'b10:   cnt_q <= cnt_q + 2'd1;
                    2'b01:   cnt_q <= cnt_q - 2'd1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        // Entry storage; contents are only meaningful while counted
        always_ff @(posedge clk) begin
            if (push[i]) mem_q[wr_q] <= din;
        end
    end

    function automatic logic [PTR_W-1:0] rr_slot(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_FU) s = s - NUM_FU;
        return PTR_W'(s);
    endfunction

    // Grant selection: first non-empty FIFO at or above rr_q, wrapping
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Walk from farthest to nearest so the nearest candidate is kept
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (nonempty[rr_slot(rr_q, k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = rr_slot(rr_q, k);
            end
        end
`ifdef CDB_FLUSH_PRIO_EN
        // A mispredicted result overrides round-robin; lowest FU index wins
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (nonempty[PTR_W'(k)] && head[PTR_W'(k)][0]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(k);
            end
        end
`endif
        gnt_entry = gnt_valid ? head[gnt_idx] : '0;
    end

    // Next round-robin start: one past the winner, wrapping at NUM_FU
    always_comb begin
        rr_d = rr_q;
        if (gnt_valid) begin
            rr_d = (gnt_idx == PTR_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst || flush) rr_q <= '0;
        else              rr_q <= rr_d;
    end

    // Registered broadcast; fields are zero whenever nothing is granted
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cdb_valid     <= 1'b0;
            cdb_rob_index <= '0;
            cdb_pd        <= '0;
            cdb_rd        <= '0;
            cdb_result    <= '0;
            cdb_regf_we   <= 1'b0;
            cdb_jump      <= 1'b0;
            cdb_br_flush  <= 1'b0;
        end else begin
            cdb_valid     <= gnt_valid;
            cdb_rob_index <= gnt_entry[ROB_LSB +: ROB_IDX_W];
            cdb_pd        <= gnt_entry[PD_LSB +: P_REG_DEPTH];
            cdb_rd        <= gnt_entry[RD_LSB +: R_REG_DEPTH];
            cdb_result    <= gnt_entry[RES_LSB +: 32];
            cdb_regf_we   <= gnt_entry[2];
            cdb_jump      <= gnt_entry[1];
            cdb_br_flush  <= gnt_entry[0];
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [3:0]    fu_valid;
    logic [3:0]    fu_ready;
    logic [15:0]   fu_rob_index;
    logic [23:0]   fu_pd;
    logic [19:0]   fu_rd;
    logic [127:0]  fu_result;
    logic [3:0]    fu_regf_we;
    logic [3:0]    fu_jump;
    logic [3:0]    fu_br_flush;
    logic          cdb_valid;
    logic [3:0]    cdb_rob_index;
    logic [5:0]    cdb_pd;
    logic [4:0]    cdb_rd;
    logic [31:0]   cdb_result;
    logic          cdb_regf_we;
    logic          cdb_jump;
    logic          cdb_br_flush;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic          mon_en = 1'b0;
    logic [49:0]   sb [$];

    cdb_arbiter #(.NUM_FU(4), .ROB_IDX_W(4), .P_REG_DEPTH(6), .R_REG_DEPTH(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_rob_index(fu_rob_index), .fu_pd(fu_pd), .fu_rd(fu_rd),
        .fu_result(fu_result), .fu_regf_we(fu_regf_we), .fu_jump(fu_jump),
        .fu_br_flush(fu_br_flush),
        .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_pd(cdb_pd),
        .cdb_rd(cdb_rd), .cdb_result(cdb_result), .cdb_regf_we(cdb_regf_we),
        .cdb_jump(cdb_jump), .cdb_br_flush(cdb_br_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [49:0] mk(input logic [3:0] rob, input logic [5:0] pd,
                                       input logic [4:0] rd, input logic [31:0] res,
                                       input logic we, input logic j, input logic bf);
        return {rob, pd, rd, res, we, j, bf};
    endfunction

    function automatic logic [49:0] cdb_rec();
        return {cdb_rob_index, cdb_pd, cdb_rd, cdb_result, cdb_regf_we, cdb_jump, cdb_br_flush};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [49:0] e);
        fu_rob_index[i*4 +: 4]  = e[49:46];
        fu_pd[i*6 +: 6]         = e[45:40];
        fu_rd[i*5 +: 5]         = e[39:35];
        fu_result[i*32 +: 32]   = e[34:3];
        fu_regf_we[i]           = e[2];
        fu_jump[i]              = e[1];
        fu_br_flush[i]          = e[0];
        fu_valid[i]             = 1'b1;
    endtask

    task automatic do_reset();
        fu_valid = 4'b0;
        flush    = 1'b0;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 30 && sb.size() != 0; c++) step();
        chk(name, 64'(sb.size()), 64'd0);
        sb.delete();
        step();
    endtask

    task automatic monitor();
        logic [49:0] exp;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cdb_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_broadcast: got %0h expected none", cdb_rec());
                    end else begin
                        exp = sb.pop_front();
                        chk("cdb_fields", 64'(cdb_rec()), 64'(exp));
                    end
                end else begin
                    chk("idle_fields_zero", 64'(cdb_rec()), 64'd0);
                end
            end
        end
    endtask

    initial begin
        logic [49:0] ea [4];
        logic [49:0] eb [4];
        logic [49:0] ec;

        rst = 1'b1; flush = 1'b0; fu_valid = '0;
        fu_rob_index = '0; fu_pd = '0; fu_rd = '0; fu_result = '0;
        fu_regf_we = '0; fu_jump = '0; fu_br_flush = '0;
        fork monitor(); join_none
        step();
        step();
        rst = 1'b0;
        chk("reset_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("reset_fields", 64'(cdb_rec()), 64'd0);
        chk("reset_fu_ready", 64'(fu_ready), 64'hF);
        mon_en = 1'b1;

        // Single FU, latency of two edges, one-cycle pulse
        ea[0] = mk(4'd5, 6'd12, 5'd3, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        sb.push_back(ea[0]);
        drive(2, ea[0]);
        step();
        fu_valid = '0;
        chk("lat_edge_k", 64'(cdb_valid), 64'd0);
        step();
        chk("lat_edge_k1", 64'(cdb_valid), 64'd1);
        step();
        chk("pulse_end", 64'(cdb_valid), 64'd0);
        drain("drain_single");

        // Contention: all four push together, broadcast in order 0..3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ea[i] = mk(4'(i + 1), 6'(8 + i), 5'(16 + i), 32'h1000_0000 + 32'(i),
                       1'(i % 2), 1'(i == 2), 1'b0);
            drive(i, ea[i]);
        end
        for (int i = 0; i < 4; i++) sb.push_back(ea[i]);
        step();
        fu_valid = '0;
        drain("drain_contend");
        // rr pointer must have wrapped to 0: FU0 beats FU3
        ea[0] = mk(4'd7, 6'd1, 5'd1, 32'h0000_00A0, 1'b1, 1'b0, 1'b0);
        ea[3] = mk(4'd8, 6'd2, 5'd2, 32'h0000_00A3, 1'b0, 1'b1, 1'b0);
        sb.push_back(ea[0]);
        sb.push_back(ea[3]);
        drive(0, ea[0]);
        drive(3, ea[3]);
        step();
        fu_valid = '0;
        drain("drain_wrap");

        // Backpressure on FU1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ea[i] = mk(4'(i), 6'(20 + i), 5'(i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
            drive(i, ea[i]);
        end
        eb[1] = mk(4'd9, 6'd33, 5'd9, 32'hB000_0011, 1'b0, 1'b0, 1'b0);
        ec    = mk(4'd10, 6'd34, 5'd10, 32'hBAD0_0BAD, 1'b1, 1'b1, 1'b1);
        sb.push_back(ea[0]);
        sb.push_back(ea[1]);
        sb.push_back(ea[2]);
        sb.push_back(ea[3]);
        sb.push_back(eb[1]);
        step();
        fu_valid = '0;
        drive(1, eb[1]);
        step();
        chk("bp_ready_full", 64'(fu_ready[1]), 64'd0);
        drive(1, ec);
        step();
        fu_valid = '0;
        chk("bp_ready_back", 64'(fu_ready[1]), 64'd1);
        drain("drain_bp");

        // Flush with three FIFOs loaded; only the pre-flush broadcast survives
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ea[i] = mk(4'(i + 4), 6'(40 + i), 5'(8 + i), 32'hC000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
            eb[i] = mk(4'(i + 12), 6'(50 + i), 5'(24 + i), 32'hC100_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
            drive(i, ea[i]);
        end
        sb.push_back(ea[0]);
        step();
        for (int i = 0; i < 3; i++) drive(i, eb[i]);
        step();
        fu_valid = '0;
        drive(3, mk(4'd15, 6'd63, 5'd31, 32'hFFFF_0000, 1'b1, 1'b1, 1'b1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        fu_valid = '0;
        chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("flush_fu_ready", 64'(fu_ready), 64'hF);
        for (int c = 0; c < 6; c++) step();
        drain("drain_flush");

        // FU0 streams one result per cycle
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk("stream_ready", 64'(fu_ready[0]), 64'd1);
            ea[0] = mk(4'(i), 6'(i * 3), 5'(i * 2), 32'hA000_0000 + 32'(i), 1'(i % 2), 1'b0, 1'b0);
            sb.push_back(ea[0]);
            drive(0, ea[0]);
            step();
            if (i >= 1) chk("stream_valid", 64'(cdb_valid), 64'd1);
        end
        fu_valid = '0;
        step();
        chk("stream_valid_last", 64'(cdb_valid), 64'd1);
        drain("drain_stream");

        // Mispredict priority
        do_reset();
        ea[0] = mk(4'd1, 6'd11, 5'd1, 32'hD000_0000, 1'b1, 1'b0, 1'b0);
        ea[3] = mk(4'd2, 6'd22, 5'd2, 32'hD000_0003, 1'b0, 1'b1, 1'b1);
`ifdef CDB_FLUSH_PRIO_EN
        sb.push_back(ea[3]);
        sb.push_back(ea[0]);
`else
        sb.push_back(ea[0]);
        sb.push_back(ea[3]);
`endif
        drive(0, ea[0]);
        drive(3, ea[3]);
        step();
        fu_valid = '0;
        drain("drain_prio");

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
